io_handshake_responder: RTL and testbench
=========================================

# io_handshake_responder

Peripheral-side responder for the control unit's I/O handshake. It watches the core's `is_input`/`is_output` request lines and returns the `confirmation` and `continue` acknowledges that gate the core's `enable`. On INPUT it latches the board switches. On OUTPUT it latches the core's value into the display register. On PAUSE it waits for the operator. It sits between the control unit and the board I/O (switches, key, 7-segment driver).

## Interface
- `DEBOUNCE_CYCLES`, default 50000: stable-sample count before a key level is accepted (1 ms at 50 MHz).
- `KEY_ACTIVE_LOW`, default 1: raw key polarity; 1 means pressed reads 0.
- `SWITCH_WIDTH`, default 16: switch bus width, ≤ 32.
- `clock` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-high.
- `is_input` in 1: request from the core. INPUT when alone, PAUSE together with `is_output`.
- `is_output` in 1: request from the core. OUTPUT when alone.
- `data_from_cpu` in 32: value to display on OUTPUT.
- `key_raw` in 1: asynchronous pushbutton.
- `switches` in SWITCH_WIDTH: asynchronous switch bank.
- `confirmation` out 1: one-cycle acknowledge for INPUT/OUTPUT.
- `continue` out 1: one-cycle acknowledge for PAUSE.
- `data_to_cpu` out 32: latched switches, zero-extended.
- `display_value` out 32: last OUTPUT value.
- `waiting` out 1: high while waiting for a key press (operator LED).

## Operation
- Key path: 2-FF synchronizer, then debouncer. The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples. `press` is a one-cycle pulse on a debounced released→pressed transition.
- Switches: 2-FF synchronized, sampled only at the capture point.
- Request decode:
  - INPUT = `is_input & ~is_output`
  - OUTPUT = `is_output & ~is_input`
  - PAUSE = `is_input & is_output`
- FSM states: IDLE, WAIT_KEY, ACK, HOLDOFF.
  - IDLE, INPUT or PAUSE → WAIT_KEY; remember the request kind.
  - IDLE, OUTPUT → ACK; `display_value` ← `data_from_cpu` on that edge.
  - WAIT_KEY, `press` → ACK. For INPUT, `data_to_cpu` ← zero-extended synchronized switches on that edge.
  - WAIT_KEY, request kind changed or dropped → IDLE, nothing latched (abort).
  - ACK: assert `confirmation` (INPUT/OUTPUT) or `continue` (PAUSE) for exactly this cycle; next state HOLDOFF.
  - HOLDOFF: all acknowledges low and requests ignored for one cycle, so the core decodes the next instruction. Then → IDLE.
- A press occurring outside WAIT_KEY is discarded and never queued.
- `confirmation` and `continue` are never high in the same cycle.
- `waiting` = (state == WAIT_KEY).
- Width: SWITCH_WIDTH < 32 means upper bits of `data_to_cpu` are 0.

## Timing
- Reset values:
  - state IDLE
  - `confirmation`, `continue`, `waiting` = 0
  - `data_to_cpu`, `display_value` = 0
  - synchronizer stages = released level
  - debounced level = released; debounce counter = 0
- Reset mid-operation (any state) returns to IDLE at once with all outputs at reset values. A pending acknowledge is lost.
- OUTPUT latency: request seen in IDLE at edge N → `display_value` updated and state ACK after edge N → `confirmation` high in cycle N+1 → HOLDOFF N+2 → IDLE N+3.
- INPUT/PAUSE: the acknowledge is high in the cycle after the edge on which `press` is sampled. `data_to_cpu` is already valid in that acknowledge cycle.
- Raw key to `press`: 2 sync cycles + DEBOUNCE_CYCLES + 1.
- Back-to-back identical requests (request held high across HOLDOFF) are served as a new transaction. An INPUT needs a fresh release and press.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package/header `io_defs`: FSM state encodings (2 bits) and request-kind encodings (NONE, INPUT, OUTPUT, PAUSE).
- Sub-module `key_debouncer`: synchronizer, counter of width clog2(DEBOUNCE_CYCLES+1), debounced level, `press` pulse.
- Top contains the request decode, FSM and data registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=1.
- OUTPUT: `is_output`=1, `data_from_cpu`=0xDEADBEEF → `display_value`=0xDEADBEEF and `confirmation` high exactly 1 cycle, at cycle N+1; `continue` stays 0.
- INPUT: `switches`=0xA5C3, `is_input`=1, key low 10 cycles → `waiting`=1 until press. `data_to_cpu`=0x0000A5C3 and `confirmation` pulses once, 8 cycles after the key falls.
- Bounce: key toggling every 2 cycles for 20 cycles, then stable high → no `press`, no acknowledge, `waiting` stays 1.
- PAUSE: `is_input`=`is_output`=1, press → `continue` 1-cycle pulse, `confirmation`=0, `data_to_cpu` unchanged.
- Abort/reset: INPUT in WAIT_KEY, drop `is_input` → IDLE, no acknowledge. Repeat and assert `reset` mid-wait → all outputs 0, state IDLE. A later press produces no acknowledge.
- Back-to-back INPUT with key held down → first acknowledged; second waits in WAIT_KEY until release and re-press.

Source files
------------

// File: rtl/io_handshake_responder_pkg.sv
// Shared encodings for the I/O handshake responder: FSM states, request kinds
// and the request decode used by the top level.
package io_handshake_responder_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_KEY = 2'd1,
        ST_ACK      = 2'd2,
        ST_HOLDOFF  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE   = 2'd0,
        REQ_INPUT  = 2'd1,
        REQ_OUTPUT = 2'd2,
        REQ_PAUSE  = 2'd3
    } req_kind_t;

    // Both request lines together encode PAUSE rather than a conflict.
    function automatic req_kind_t decode_request(input logic is_input, input logic is_output);
        req_kind_t kind;
        case ({is_input, is_output})
            2'b10:   kind = REQ_INPUT;
            2'b01:   kind = REQ_OUTPUT;
            2'b11:   kind = REQ_PAUSE;
            default: kind = REQ_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/io_handshake_responder_if.sv
// Core-side handshake bundle: request lines and data from the control unit,
// acknowledges and input data back to it.
interface io_handshake_responder_if;

    logic                                              is_input;
    logic                                              is_output;
    logic [io_handshake_responder_pkg::DATA_WIDTH-1:0] data_from_cpu;
    logic                                              confirmation;
    logic                                              continue_ack;
    logic [io_handshake_responder_pkg::DATA_WIDTH-1:0] data_to_cpu;

    modport master (
        output is_input,
        output is_output,
        output data_from_cpu,
        input  confirmation,
        input  continue_ack,
        input  data_to_cpu
    );

    modport slave (
        input  is_input,
        input  is_output,
        input  data_from_cpu,
        output confirmation,
        output continue_ack,
        output data_to_cpu
    );

endinterface

// File: rtl/io_handshake_responder_key_debouncer.sv
// Pushbutton conditioning: 2-FF synchronizer, counting debouncer and a
// one-cycle press pulse on each debounced released-to-pressed transition.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw,
    output logic press
);

    localparam int   CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic RELEASED = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [1:0]       sync_reg;
    logic             level_reg;
    logic [CNT_W-1:0] count_reg;
    logic             press_reg;

    // level_reg stays in raw key polarity; only the press decode needs to know it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_reg  <= {2{RELEASED}};
            level_reg <= RELEASED;
            count_reg <= '0;
            press_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], key_raw};
            press_reg <= 1'b0;
            if (sync_reg[1] == level_reg) begin
                count_reg <= '0;
            end else if (count_reg == CNT_W'(DEBOUNCE_CYCLES)) begin
                level_reg <= sync_reg[1];
                count_reg <= '0;
                press_reg <= (sync_reg[1] != RELEASED);
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/io_handshake_responder.sv
// Peripheral-side responder for the core's I/O handshake: decodes requests,
// waits for the operator key where needed and returns one-cycle acknowledges.
module io_handshake_responder
    import io_handshake_responder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1,
    parameter int SWITCH_WIDTH    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    io_handshake_responder_if.slave cpu,
    input  logic                    key_raw,
    input  logic [SWITCH_WIDTH-1:0] switches,
    output logic [DATA_WIDTH-1:0]   display_value,
    output logic                    waiting
);

    logic press;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_key_debouncer (
        .clock   (clock),
        .reset   (reset),
        .key_raw (key_raw),
        .press   (press)
    );

    logic [SWITCH_WIDTH-1:0] sw_meta_reg;
    logic [SWITCH_WIDTH-1:0] sw_sync_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta_reg <= '0;
            sw_sync_reg <= '0;
        end else begin
            sw_meta_reg <= switches;
            sw_sync_reg <= sw_meta_reg;
        end
    end

    req_kind_t req_kind;
    assign req_kind = decode_request(cpu.is_input, cpu.is_output);

    state_t                state_reg, state_next;
    req_kind_t             kind_reg, kind_next;
    logic                  confirmation_reg, confirmation_next;
    logic                  continue_reg, continue_next;
    logic                  waiting_reg, waiting_next;
    logic [DATA_WIDTH-1:0] data_to_cpu_reg, data_to_cpu_next;
    logic [DATA_WIDTH-1:0] display_reg, display_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            kind_reg         <= REQ_NONE;
            confirmation_reg <= 1'b0;
            continue_reg     <= 1'b0;
            waiting_reg      <= 1'b0;
            data_to_cpu_reg  <= '0;
            display_reg      <= '0;
        end else begin
            state_reg        <= state_next;
            kind_reg         <= kind_next;
            confirmation_reg <= confirmation_next;
            continue_reg     <= continue_next;
            waiting_reg      <= waiting_next;
            data_to_cpu_reg  <= data_to_cpu_next;
            display_reg      <= display_next;
        end
    end

    // Abort takes priority over a coincident press: a changed request never acknowledges.
    always_comb begin
        state_next = state_reg;
        kind_next  = kind_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_kind == REQ_INPUT || req_kind == REQ_PAUSE) begin
                    state_next = ST_WAIT_KEY;
                    kind_next  = req_kind;
                end else if (req_kind == REQ_OUTPUT) begin
                    state_next = ST_ACK;
                    kind_next  = REQ_OUTPUT;
                end
            end
            ST_WAIT_KEY: begin
                if (req_kind != kind_reg) begin
                    state_next = ST_IDLE;
                    kind_next  = REQ_NONE;
                end else if (press) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK:     state_next = ST_HOLDOFF;
            ST_HOLDOFF: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in the state they describe.
    always_comb begin
        confirmation_next = (state_next == ST_ACK) && (kind_next != REQ_PAUSE);
        continue_next     = (state_next == ST_ACK) && (kind_next == REQ_PAUSE);
        waiting_next      = (state_next == ST_WAIT_KEY);
        display_next      = display_reg;
        data_to_cpu_next  = data_to_cpu_reg;
        if (state_reg == ST_IDLE && state_next == ST_ACK) begin
            display_next = cpu.data_from_cpu;
        end
        if (state_reg == ST_WAIT_KEY && state_next == ST_ACK && kind_reg == REQ_INPUT) begin
            data_to_cpu_next = DATA_WIDTH'(sw_sync_reg);
        end
    end

    assign cpu.confirmation = confirmation_reg;
    assign cpu.continue_ack = continue_reg;
    assign cpu.data_to_cpu  = data_to_cpu_reg;
    assign display_value    = display_reg;
    assign waiting          = waiting_reg;

endmodule

// File: tb/tb_io_handshake_responder.sv
// Scenario bench for io_handshake_responder with a scoreboard of expected acknowledges.
module tb_io_handshake_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        key_raw = 1'b1;
    logic [15:0] switches = 16'h0;
    logic [31:0] display_value;
    logic        waiting;

    io_handshake_responder_if bus();

    io_handshake_responder #(
        .DEBOUNCE_CYCLES (4),
        .KEY_ACTIVE_LOW  (1'b1),
        .SWITCH_WIDTH    (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu           (bus),
        .key_raw       (key_raw),
        .switches      (switches),
        .display_value (display_value),
        .waiting       (waiting)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        conf;
        logic        cont;
        logic [31:0] dtc;
        logic [31:0] disp;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   ack_count    = 0;

    // Acknowledge monitor: acks are stable from posedge to posedge, so the negedge sees each once.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (bus.confirmation === 1'b1 && bus.continue_ack === 1'b1) begin
                tests_run++;
                tests_failed++;
                $display("FAIL ack_exclusive: confirmation=1 continue=1, required not both");
            end
            if (bus.confirmation === 1'b1 || bus.continue_ack === 1'b1) begin
                ack_count++;
                tests_run++;
                $display("[TB] ack conf=%0b cont=%0b data_to_cpu=%h display=%h",
                         bus.confirmation, bus.continue_ack, bus.data_to_cpu, display_value);
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_ack: conf=%0b cont=%0b, required no acknowledge",
                             bus.confirmation, bus.continue_ack);
                end else begin
                    e = sb.pop_front();
                    if ({bus.confirmation, bus.continue_ack, bus.data_to_cpu, display_value}
                        !== {e.conf, e.cont, e.dtc, e.disp}) begin
                        tests_failed++;
                        $display("FAIL ack_contents: got conf=%0b cont=%0b dtc=%h disp=%h, required conf=%0b cont=%0b dtc=%h disp=%h",
                                 bus.confirmation, bus.continue_ack, bus.data_to_cpu, display_value,
                                 e.conf, e.cont, e.dtc, e.disp);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        tests_run++;
        if ({bus.confirmation, bus.continue_ack, waiting, bus.data_to_cpu, display_value} !== 67'b0) begin
            tests_failed++;
            $display("FAIL reset_held: conf=%0b cont=%0b wait=%0b dtc=%h disp=%h, required all 0",
                     bus.confirmation, bus.continue_ack, waiting, bus.data_to_cpu, display_value);
        end
        reset = 1'b0;
        repeat (3) tick();
        tests_run++;
        if ({bus.confirmation, bus.continue_ack, waiting, bus.data_to_cpu, display_value} !== 67'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: conf=%0b cont=%0b wait=%0b dtc=%h disp=%h, required all 0",
                     bus.confirmation, bus.continue_ack, waiting, bus.data_to_cpu, display_value);
        end
    endtask

    task automatic test_output();
        bus.data_from_cpu = 32'hDEADBEEF;
        bus.is_output     = 1'b1;
        sb.push_back('{1'b1, 1'b0, 32'h0, 32'hDEADBEEF});
        tick();
        tests_run++;
        if ({bus.confirmation, bus.continue_ack, display_value} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            tests_failed++;
            $display("FAIL output_ack: conf=%0b cont=%0b disp=%h, required conf=1 cont=0 disp=deadbeef",
                     bus.confirmation, bus.continue_ack, display_value);
        end
        bus.is_output = 1'b0;
        tick();
        tests_run++;
        if (bus.confirmation !== 1'b0) begin
            tests_failed++;
            $display("FAIL output_holdoff: conf=%0b, required 0", bus.confirmation);
        end
        tick();
        tests_run++;
        if (bus.confirmation !== 1'b0 || display_value !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL output_after: conf=%0b disp=%h, required conf=0 disp=deadbeef",
                     bus.confirmation, display_value);
        end
    endtask

    task automatic test_input();
        switches     = 16'hA5C3;
        bus.is_input = 1'b1;
        tick();
        tests_run++;
        if (waiting !== 1'b1) begin
            tests_failed++;
            $display("FAIL input_waiting: waiting=%0b, required 1", waiting);
        end
        repeat (3) tick();
        key_raw = 1'b0;
        sb.push_back('{1'b1, 1'b0, 32'h0000A5C3, 32'hDEADBEEF});
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i < 8) begin
                tests_run++;
                if (bus.confirmation !== 1'b0 || waiting !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL input_early cycle %0d: conf=%0b waiting=%0b, required conf=0 waiting=1",
                             i, bus.confirmation, waiting);
                end
            end
        end
        tests_run++;
        if ({bus.confirmation, waiting, bus.data_to_cpu} !== {1'b1, 1'b0, 32'h0000A5C3}) begin
            tests_failed++;
            $display("FAIL input_ack: conf=%0b waiting=%0b dtc=%h, required conf=1 waiting=0 dtc=0000a5c3",
                     bus.confirmation, waiting, bus.data_to_cpu);
        end
        bus.is_input = 1'b0;
        key_raw      = 1'b1;
        tick();
        tests_run++;
        if (bus.confirmation !== 1'b0) begin
            tests_failed++;
            $display("FAIL input_single_pulse: conf=%0b, required 0", bus.confirmation);
        end
        repeat (10) tick();
    endtask

    task automatic test_bounce();
        int a;
        switches     = 16'h1111;
        bus.is_input = 1'b1;
        tick();
        a = ack_count;
        for (int i = 0; i < 20; i++) begin
            key_raw = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
        end
        key_raw = 1'b1;
        repeat (10) tick();
        tests_run++;
        if (ack_count !== a || waiting !== 1'b1) begin
            tests_failed++;
            $display("FAIL bounce: acks=%0d waiting=%0b, required acks=%0d waiting=1", ack_count, waiting, a);
        end
        bus.is_input = 1'b0;
        tick();
        tests_run++;
        if (waiting !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_abort: waiting=%0b, required 0", waiting);
        end
        repeat (2) tick();
    endtask

    task automatic test_pause();
        bit found = 1'b0;
        switches      = 16'h1234;
        bus.is_input  = 1'b1;
        bus.is_output = 1'b1;
        tick();
        tests_run++;
        if (waiting !== 1'b1) begin
            tests_failed++;
            $display("FAIL pause_waiting: waiting=%0b, required 1", waiting);
        end
        repeat (3) tick();
        key_raw = 1'b0;
        sb.push_back('{1'b0, 1'b1, 32'h0000A5C3, 32'hDEADBEEF});
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.continue_ack === 1'b1) found = 1'b1;
        end
        tests_run++;
        if (!found || bus.confirmation !== 1'b0 || bus.data_to_cpu !== 32'h0000A5C3) begin
            tests_failed++;
            $display("FAIL pause_ack: continue_seen=%0b conf=%0b dtc=%h, required continue_seen=1 conf=0 dtc=0000a5c3",
                     found, bus.confirmation, bus.data_to_cpu);
        end
        bus.is_input  = 1'b0;
        bus.is_output = 1'b0;
        key_raw       = 1'b1;
        tick();
        tests_run++;
        if (bus.continue_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL pause_single_pulse: continue=%0b, required 0", bus.continue_ack);
        end
        repeat (10) tick();
    endtask

    task automatic test_abort_reset();
        int a = ack_count;
        bus.is_input = 1'b1;
        tick();
        tick();
        bus.is_input = 1'b0;
        tick();
        repeat (3) tick();
        tests_run++;
        if (waiting !== 1'b0 || ack_count !== a) begin
            tests_failed++;
            $display("FAIL abort: waiting=%0b acks=%0d, required waiting=0 acks=%0d", waiting, ack_count, a);
        end
        bus.is_input = 1'b1;
        tick();
        tests_run++;
        if (waiting !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_rewait: waiting=%0b, required 1", waiting);
        end
        key_raw = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        tests_run++;
        if ({bus.confirmation, bus.continue_ack, waiting, bus.data_to_cpu, display_value} !== 67'b0) begin
            tests_failed++;
            $display("FAIL reset_midwait: conf=%0b cont=%0b wait=%0b dtc=%h disp=%h, required all 0",
                     bus.confirmation, bus.continue_ack, waiting, bus.data_to_cpu, display_value);
        end
        bus.is_input = 1'b0;
        tick();
        reset = 1'b0;
        repeat (15) tick();
        tests_run++;
        if (ack_count !== a || waiting !== 1'b0) begin
            tests_failed++;
            $display("FAIL press_after_reset: acks=%0d waiting=%0b, required acks=%0d waiting=0", ack_count, waiting, a);
        end
        key_raw = 1'b1;
        repeat (10) tick();
    endtask

    task automatic test_back_to_back();
        int  a;
        bit  found = 1'b0;
        switches = 16'h00FF;
        repeat (3) tick();
        bus.is_input = 1'b1;
        tick();
        key_raw = 1'b0;
        sb.push_back('{1'b1, 1'b0, 32'h000000FF, 32'h0});
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.confirmation === 1'b1) found = 1'b1;
        end
        tests_run++;
        if (!found || bus.data_to_cpu !== 32'h000000FF) begin
            tests_failed++;
            $display("FAIL b2b_first: conf_seen=%0b dtc=%h, required conf_seen=1 dtc=000000ff", found, bus.data_to_cpu);
        end
        repeat (3) tick();
        tests_run++;
        if (waiting !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_rewait: waiting=%0b, required 1", waiting);
        end
        a = ack_count;
        repeat (15) tick();
        switches = 16'h0F0F;
        key_raw  = 1'b1;
        repeat (10) tick();
        tests_run++;
        if (ack_count !== a || waiting !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_held: acks=%0d waiting=%0b, required acks=%0d waiting=1", ack_count, waiting, a);
        end
        sb.push_back('{1'b1, 1'b0, 32'h00000F0F, 32'h0});
        key_raw = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.confirmation === 1'b1) found = 1'b1;
        end
        tests_run++;
        if (!found || bus.data_to_cpu !== 32'h00000F0F) begin
            tests_failed++;
            $display("FAIL b2b_second: conf_seen=%0b dtc=%h, required conf_seen=1 dtc=00000f0f", found, bus.data_to_cpu);
        end
        bus.is_input = 1'b0;
        key_raw      = 1'b1;
        repeat (10) tick();
    endtask

    initial begin
        bus.is_input      = 1'b0;
        bus.is_output     = 1'b0;
        bus.data_from_cpu = 32'h0;
        test_reset();
        test_output();
        test_input();
        test_bounce();
        test_pause();
        test_abort_reset();
        test_back_to_back();
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
